// File: rtl/led_panel_receiver.sv
// LED panel receiver: captures a HUB75-style shifted row (top and bottom
// half RGB bits) clocked by an asynchronous panel shift clock. On each
// panel latch strobe the row is snapshotted and replayed into a row buffer
// as one {row, column} word per system clock, column 0 first.
module led_panel_receiver #(
    parameter int NUM_COLS  = 64,
    parameter int ADDR_BITS = 4
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 bit_clk_in,
    input  logic [2:0]                           rgb_top_in,
    input  logic [2:0]                           rgb_bot_in,
    input  logic [ADDR_BITS-1:0]                 addr_in,
    input  logic                                 latch_enable_in,
    output logic                                 wr_en_out,
    output logic [ADDR_BITS+$clog2(NUM_COLS)-1:0] wr_addr_out,
    output logic [5:0]                           wr_data_out,
    output logic                                 busy_out,
    output logic                                 row_done_out,
    output logic                                 frame_done_out,
    output logic                                 row_drop_out,
    output logic                                 overflow_out
);

    localparam int COL_BITS = $clog2(NUM_COLS);
    localparam int WA_BITS  = ADDR_BITS + COL_BITS;
    // Shift counter must represent NUM_COLS+1 (the saturation value).
    localparam int CNT_BITS = $clog2(NUM_COLS + 2);
    // Synchroniser bundle: {latch, addr, top rgb, bottom rgb, bit_clk}.
    localparam int SYNC_W   = ADDR_BITS + 8;

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(NUM_COLS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(NUM_COLS + 1);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(NUM_COLS);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_W-1:0] sync_in;
    logic [SYNC_W-1:0] sync1_q;
    logic [SYNC_W-1:0] sync2_q;
    logic              bclk_prev_q;
    logic              latch_prev_q;

    // Data travels with the strobes through the same two stages, so the
    // pixel bits and address line up with the edge that qualifies them.
    assign sync_in = {latch_enable_in, addr_in, rgb_top_in, rgb_bot_in, bit_clk_in};

    logic                 s_bclk;
    logic                 s_latch;
    logic [5:0]           s_pix;
    logic [ADDR_BITS-1:0] s_addr;
    logic                 bclk_rise;
    logic                 latch_rise;

    assign s_bclk     = sync2_q[0];
    assign s_pix      = sync2_q[6:1];
    assign s_addr     = sync2_q[ADDR_BITS+6:7];
    assign s_latch    = sync2_q[ADDR_BITS+7];
    assign bclk_rise  = s_bclk & ~bclk_prev_q;
    assign latch_rise = s_latch & ~latch_prev_q;

    // Two-flop synchroniser plus previous-value registers for edge detection.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            bclk_prev_q  <= 1'b0;
            latch_prev_q <= 1'b0;
        end else begin
            sync1_q      <= sync_in;
            sync2_q      <= sync1_q;
            bclk_prev_q  <= s_bclk;
            latch_prev_q <= s_latch;
        end
    end

    // ------------------------------------------------------------------
    // Shift register and shift counter
    // ------------------------------------------------------------------
    logic [5:0]          sr_q [NUM_COLS];
    logic [5:0]          sr_d [NUM_COLS];
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_shifted;
    logic [CNT_BITS-1:0] cnt_d;
    logic                ovf_hit;

    // Next shift-register contents; the latch snapshot also uses sr_d so a
    // shift detected in the same cycle as the latch is included.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sr_d = sr_q;
        if (bclk_rise) begin
            sr_d[0] = s_pix;
            for (int i = 1; i < NUM_COLS; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    // Shift count saturates one past a full row, which is enough to flag
    // overflow without wrapping; it restarts on every detected latch.
    always_comb begin
        cnt_shifted = cnt_q;
        if (bclk_rise && (cnt_q != CNT_MAX)) begin
            cnt_shifted = cnt_q + 1'b1;
        end
        ovf_hit = (cnt_shifted > CNT_FULL);
        cnt_d   = latch_rise ? '0 : cnt_shifted;
    end

    // Shift register and counter state.
    // NOTE: the shift register is explicitly cleared in reset because a
    // partially shifted row must never leak into a post-reset snapshot.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                sr_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Write-out FSM with registered outputs
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [5:0]           buf_q [NUM_COLS];
    logic [ADDR_BITS-1:0] row_q;
    logic [COL_BITS-1:0]  col_q;
    logic                 wr_en_q;
    logic [WA_BITS-1:0]   wr_addr_q;
    logic [5:0]           wr_data_q;
    logic                 row_done_q;
    logic                 frame_done_q;
    logic                 row_drop_q;
    logic                 overflow_q;
    logic                 last_write;

    // The word currently on the write port is the final column of its row.
    assign last_write = wr_en_q && (wr_addr_q[COL_BITS-1:0] == LAST_COL);

    // Snapshot on latch in IDLE, then stream one buffer word per cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            for (int i = 0; i < NUM_COLS; i++) begin
                buf_q[i] <= '0;
            end
            row_q        <= '0;
            col_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            row_drop_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            row_drop_q   <= 1'b0;
            row_done_q   <= last_write;
            frame_done_q <= last_write && (&wr_addr_q[WA_BITS-1:COL_BITS]);
            overflow_q   <= latch_rise && ovf_hit;

            case (state_q)
                IDLE: begin
                    if (latch_rise) begin
                        buf_q   <= sr_d;
                        row_q   <= s_addr;
                        col_q   <= '0;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= {row_q, col_q};
                    wr_data_q <= buf_q[col_q];
                    col_q     <= col_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        state_q <= IDLE;
                    end
                    // A latch during a burst is dropped; the buffer is untouched.
                    if (latch_rise) begin
                        row_drop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en_out      = wr_en_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign busy_out       = (state_q == WRITE);
    assign row_done_out   = row_done_q;
    assign frame_done_out = frame_done_q;
    assign row_drop_out   = row_drop_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_led_panel_receiver.sv
// Directed testbench for led_panel_receiver (NUM_COLS=64, ADDR_BITS=4).
module tb_led_panel_receiver;

    localparam int NC = 64;
    localparam int AB = 4;
    localparam int AW = 10;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          bit_clk_in;
    logic [2:0]    rgb_top_in;
    logic [2:0]    rgb_bot_in;
    logic [AB-1:0] addr_in;
    logic          latch_enable_in;
    logic          wr_en_out;
    logic [AW-1:0] wr_addr_out;
    logic [5:0]    wr_data_out;
    logic          busy_out;
    logic          row_done_out;
    logic          frame_done_out;
    logic          row_drop_out;
    logic          overflow_out;

    led_panel_receiver #(.NUM_COLS(NC), .ADDR_BITS(AB)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .bit_clk_in      (bit_clk_in),
        .rgb_top_in      (rgb_top_in),
        .rgb_bot_in      (rgb_bot_in),
        .addr_in         (addr_in),
        .latch_enable_in (latch_enable_in),
        .wr_en_out       (wr_en_out),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .busy_out        (busy_out),
        .row_done_out    (row_done_out),
        .frame_done_out  (frame_done_out),
        .row_drop_out    (row_drop_out),
        .overflow_out    (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: records every write and counts every pulse output.
    logic [AW-1:0] cap_addr [1024];
    logic [5:0]    cap_data [1024];
    int            cap_cyc  [1024];
    int wr_cnt = 0, done_cnt = 0, done_cyc = 0, frame_cnt = 0, frame_with_row = 0;
    int ovf_cnt = 0, drop_cnt = 0;

    always @(negedge clk_in) begin
        if (wr_en_out) begin
            if (wr_cnt < 1024) begin
                cap_addr[wr_cnt] = wr_addr_out;
                cap_data[wr_cnt] = wr_data_out;
                cap_cyc[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (row_done_out) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (frame_done_out) begin
            frame_cnt = frame_cnt + 1;
            if (row_done_out) frame_with_row = frame_with_row + 1;
        end
        if (overflow_out) ovf_cnt = ovf_cnt + 1;
        if (row_drop_out) drop_cnt = drop_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected pixel at column c: 0 -> 64 shifts of k, 1 -> 64 shifts of 63-k,
    // 2 -> 66 shifts of k (two oldest pixels discarded).
    function automatic logic [5:0] exp_px(input int mode, input int c);
        int v;
        case (mode)
            0:       v = 63 - c;
            1:       v = c;
            default: v = (65 - c) & 63;
        endcase
        return 6'(v);
    endfunction

    task automatic shift_px(input logic [5:0] px);
        rgb_top_in = px[5:3];
        rgb_bot_in = px[2:0];
        bit_clk_in = 1'b0;
        repeat (4) @(negedge clk_in);
        bit_clk_in = 1'b1;
        repeat (4) @(negedge clk_in);
        bit_clk_in = 1'b0;
    endtask

    task automatic shift_row(input int mode);
        for (int k = 0; k < NC; k++) begin
            shift_px(mode == 0 ? 6'(k) : 6'(63 - k));
        end
    endtask

    task automatic pulse_latch(input logic [AB-1:0] a, output int start);
        @(negedge clk_in);
        addr_in = a;
        repeat (3) @(negedge clk_in);
        latch_enable_in = 1'b1;
        start = cyc;
        repeat (4) @(negedge clk_in);
        latch_enable_in = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        if (wr_cnt < target) check({tag, "_write_timeout"}, wr_cnt, target);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        if (done_cnt < target) check({tag, "_done_timeout"}, done_cnt, target);
    endtask

    task automatic check_burst(input string tag, input int base, input logic [AB-1:0] row,
                               input int mode, input int start);
        check({tag, "_latency"}, cap_cyc[base] - start, 4);
        check({tag, "_done_gap"}, done_cyc - cap_cyc[base+NC-1], 1);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s_addr[%0d]", tag, c), cap_addr[base+c], {row, 6'(c)});
            check($sformatf("%s_data[%0d]", tag, c), cap_data[base+c], exp_px(mode, c));
            if (c > 0) check($sformatf("%s_contig[%0d]", tag, c), cap_cyc[base+c] - cap_cyc[base+c-1], 1);
        end
    endtask

    int base, d0, f0, fr0, o0, dr0, ls, ls2;

    task automatic snap();
        base = wr_cnt; d0 = done_cnt; f0 = frame_cnt; fr0 = frame_with_row;
        o0 = ovf_cnt; dr0 = drop_cnt;
    endtask

    initial begin
        reset_in = 1'b1;
        bit_clk_in = 1'b0;
        rgb_top_in = '0;
        rgb_bot_in = '0;
        addr_in = '0;
        latch_enable_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_wr_en", wr_en_out, 0);
        check("rst_wr_addr", wr_addr_out, 0);
        check("rst_wr_data", wr_data_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_pulses", {row_done_out, frame_done_out, row_drop_out, overflow_out}, 0);
        reset_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Full row, addr 5.
        snap();
        shift_row(0);
        pulse_latch(4'd5, ls);
        check("t031_busy", busy_out, 1);
        wait_writes("t031", base + NC, 200);
        wait_done("t031", d0 + 1, 50);
        check_burst("t031", base, 4'd5, 0, ls);
        check("t031_frame", frame_cnt - f0, 0);
        check("t031_ovf", ovf_cnt - o0, 0);
        check("t031_busy_end", busy_out, 0);

        // Re-latch the same contents at the all-ones row.
        snap();
        pulse_latch(4'd15, ls);
        wait_writes("t032", base + NC, 200);
        wait_done("t032", d0 + 1, 50);
        check_burst("t032", base, 4'd15, 0, ls);
        check("t032_frame", frame_cnt - f0, 1);
        check("t032_frame_with_row", frame_with_row - fr0, 1);

        // Over-length shift.
        snap();
        for (int k = 0; k < NC + 2; k++) shift_px(6'(k));
        pulse_latch(4'd6, ls);
        wait_writes("t033", base + NC, 200);
        wait_done("t033", d0 + 1, 50);
        check("t033_ovf", ovf_cnt - o0, 1);
        check_burst("t033", base, 4'd6, 2, ls);

        // Latch during a burst is dropped.
        snap();
        shift_row(0);
        pulse_latch(4'd3, ls);
        wait_writes("t034", base + 10, 100);
        pulse_latch(4'd12, ls2);
        wait_done("t034", d0 + 1, 200);
        repeat (80) @(negedge clk_in);
        #1;
        check("t034_drop", drop_cnt - dr0, 1);
        check("t034_writes", wr_cnt - base, NC);
        check("t034_done", done_cnt - d0, 1);
        check("t034_ovf", ovf_cnt - o0, 0);
        check_burst("t034", base, 4'd3, 0, ls);

        // Shift a new row while a burst runs, latch it afterwards.
        snap();
        shift_row(0);
        pulse_latch(4'd8, ls);
        shift_row(1);
        wait_done("t035a", d0 + 1, 50);
        check_burst("t035a", base, 4'd8, 0, ls);
        pulse_latch(4'd9, ls2);
        wait_writes("t035b", base + 2 * NC, 200);
        wait_done("t035b", d0 + 2, 50);
        check_burst("t035b", base + NC, 4'd9, 1, ls2);
        check("t035_ovf", ovf_cnt - o0, 0);

        // Reset mid-burst, then a clean capture.
        snap();
        shift_row(0);
        pulse_latch(4'd7, ls);
        wait_writes("t036", base + 20, 100);
        reset_in = 1'b1;
        @(negedge clk_in);
        #1;
        check("t036_wr_en", wr_en_out, 0);
        check("t036_busy", busy_out, 0);
        @(negedge clk_in);
        #1;
        reset_in = 1'b0;
        repeat (80) @(negedge clk_in);
        #1;
        check("t036_writes", wr_cnt - base, 20);
        check("t036_done", done_cnt - d0, 0);
        snap();
        shift_row(1);
        pulse_latch(4'd2, ls);
        wait_writes("t036b", base + NC, 200);
        wait_done("t036b", d0 + 1, 50);
        check_burst("t036b", base, 4'd2, 1, ls);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_panel_receiver.md
LED_PANEL_RECEIVER -- requirements
Module: led_panel_receiver

Interface
REQ-001 Parameter NUM_COLS, default 64, SHALL set the pixels per shifted row (power of two, ≥2).
REQ-002 Parameter ADDR_BITS, default 4, SHALL set the width of the panel row-address bus.
REQ-003 clk_in  input  1  SHALL be the system clock; all logic is on its rising edge.
REQ-004 reset_in  input  1  SHALL be a synchronous, active-high reset.
REQ-005 bit_clk_in  input  1  SHALL be the panel shift clock, asynchronous to clk_in.
REQ-006 rgb_top_in  input  3  SHALL be top-half pixel bits {R,G,B}, valid at bit_clk_in rise.
REQ-007 rgb_bot_in  input  3  SHALL be bottom-half pixel bits {R,G,B}, valid at bit_clk_in rise.
REQ-008 addr_in  input  ADDR_BITS  SHALL be the panel row address, stable while latch_enable_in is high.
REQ-009 latch_enable_in  input  1  SHALL be the panel latch strobe, active-high, asynchronous.
REQ-010 wr_en_out  output  1  SHALL be the row-buffer write strobe, one word per cycle.
REQ-011 wr_addr_out  output  ADDR_BITS+log2(NUM_COLS)  SHALL be {row, column}.
REQ-012 wr_data_out  output  6  SHALL be {top R,G,B, bottom R,G,B}, top in bits [5:3].
REQ-013 busy_out  output  1  SHALL be high while a write-out burst is in progress.
REQ-014 row_done_out  output  1  SHALL pulse one cycle when a burst completes.
REQ-015 frame_done_out  output  1  SHALL pulse with row_done_out when the completed row address is all-ones.
REQ-016 row_drop_out  output  1  SHALL pulse one cycle when a latch is ignored because busy.
REQ-017 overflow_out  output  1  SHALL pulse one cycle at a latch preceded by more than NUM_COLS shifts.

Function
REQ-018 bit_clk_in, rgb_*_in, latch_enable_in and addr_in SHALL pass through an identical 2-flop synchroniser; edges SHALL be detected from stage 2 against a registered previous value.
REQ-019 Inputs SHALL be supported when bit_clk_in and latch_enable_in high/low phases are each ≥3 clk_in cycles.
REQ-020 On a detected bit_clk rise, the shift register SHALL shift: col[i] <= col[i-1], col[0] <= {top,bot}; so after exactly NUM_COLS shifts the first pixel sits at column NUM_COLS-1.
REQ-021 Shifts beyond NUM_COLS SHALL discard the oldest pixel; a shift counter SHALL saturate at NUM_COLS+1 and clear on every detected latch.
REQ-022 FSM states: IDLE, WRITE. IDLE->WRITE on a detected latch_enable rise; WRITE->IDLE after column NUM_COLS-1 is written.
REQ-023 On latch in IDLE, the shift register SHALL be copied to a latch buffer and synchronised addr_in captured as row; the shift register SHALL keep running independently.
REQ-024 If a bit_clk rise and latch rise are detected in the same cycle, the shift SHALL be applied before the snapshot.
REQ-025 A latch detected in WRITE SHALL be ignored (buffer and row unchanged) and SHALL pulse row_drop_out; the shift counter still clears.
REQ-026 Latency: wr_en_out SHALL first assert 4 clk_in cycles after latch_enable_in rises at the pin, then stay high NUM_COLS consecutive cycles, column 0 first, ascending.
REQ-027 busy_out SHALL equal (state == WRITE); row_done_out SHALL pulse in the cycle after the last write.
REQ-028 overflow_out SHALL pulse in the snapshot cycle when the shift counter exceeded NUM_COLS, whether or not the latch is dropped.

Reset
REQ-029 While reset_in is high, all outputs SHALL be 0, FSM SHALL be IDLE, shift register, latch buffer, counters and synchronisers SHALL clear to 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst on the next edge with no further writes and no row_done_out.

Verification
REQ-031 64 shifts with pixel k = k[5:0] then latch with addr 5 -> 64 writes, addr {5,c}, data 63-c; row_done pulse; frame_done 0.
REQ-032 Row addr 15 (all-ones) latched -> frame_done_out and row_done_out pulse together.
REQ-033 66 shifts (values 0..65) then latch -> overflow_out pulse; column c data = (65-c)[5:0].
REQ-034 Second latch 10 cycles into a burst -> row_drop_out pulse; burst completes with first row data unchanged.
REQ-035 Shifting 64 new pixels during a burst, then latch after row_done -> second burst carries only new pixels.
REQ-036 reset_in high at write 20 -> wr_en_out 0 next cycle, busy_out 0, no row_done; subsequent row captures correctly.
